// File: rtl/cpr_stream_ctrl_pkg.sv
// Shared types and default widths for the cyclic-prefix-removal stream controller.
package cpr_pkg;

  localparam int CPR_CNT_W = 12;
  localparam int CPR_SYM_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DROP,
    ST_PASS,
    ST_FLUSH
  } cpr_state_e;

endpackage

// File: rtl/cpr_stream_ctrl_out_reg.sv
// One-entry AXI-stream register slice; a load in the same cycle as an accept keeps it full.
module cpr_out_reg
  import cpr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              valid,
  input  logic              ready,
  output logic              empty
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data  <= '0;
      last  <= 1'b0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      last  <= load_last;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

  assign empty = !valid;

endmodule

// File: rtl/cpr_stream_ctrl.sv
// Cyclic-prefix removal sequencer: drops cp_len samples, passes fft_len samples per symbol.
// Optional watchdog built when CPR_WATCHDOG_EN is defined; otherwise stall_flag is constant 0.
module cpr_stream_ctrl
  import cpr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = CPR_CNT_W,
  parameter int SYM_W  = CPR_SYM_W,
  parameter int WD_W   = 16
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  input  logic [CNT_W-1:0]  cfg_cp_len,
  input  logic [CNT_W-1:0]  cfg_fft_len,
  input  logic [SYM_W-1:0]  cfg_num_sym,
  input  logic [DATA_W-1:0] inpstream_TDATA,
  input  logic              inpstream_TVALID,
  output logic              inpstream_TREADY,
  output logic [DATA_W-1:0] oupstream_TDATA,
  output logic              oupstream_TVALID,
  input  logic              oupstream_TREADY,
  output logic              oupstream_TLAST,
  output logic              inpstream_TDATA_blk_n,
  output logic              oupstream_TDATA_blk_n,
  output logic              stall_flag
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [SYM_W-1:0] SYM_ONE = SYM_W'(1);

  cpr_state_e       state, state_d;
  logic [CNT_W-1:0] cnt, cp_q, fft_q;
  logic [SYM_W-1:0] sym_cnt, num_q;
  logic             start_acc, load, in_hs, out_hs, out_empty;
  logic             cp_last, fft_last, sym_last;

  assign cp_last  = (cnt == cp_q - CNT_ONE);
  assign fft_last = (cnt == fft_q - CNT_ONE);
  assign sym_last = (sym_cnt == num_q - SYM_ONE);
  assign in_hs    = inpstream_TVALID && inpstream_TREADY;
  assign out_hs   = oupstream_TVALID && oupstream_TREADY;

  always_comb begin
    state_d          = state;
    inpstream_TREADY = 1'b0;
    start_acc        = 1'b0;
    load             = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ap_start) begin
          start_acc = 1'b1;
          state_d   = (cfg_cp_len == '0) ? ST_PASS : ST_DROP;
        end
      end
      ST_DROP: begin
        inpstream_TREADY = 1'b1;
        if (inpstream_TVALID && cp_last) state_d = ST_PASS;
      end
      ST_PASS: begin
        inpstream_TREADY = out_empty || oupstream_TREADY;
        if (inpstream_TVALID && inpstream_TREADY) begin
          load = 1'b1;
          if (fft_last)
            state_d = sym_last ? ST_FLUSH : ((cp_q == '0) ? ST_PASS : ST_DROP);
        end
      end
      ST_FLUSH: begin
        if (out_hs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Zero-length fields are clamped to 1 at latch time so the count compares stay simple.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      sym_cnt <= '0;
      cp_q    <= '0;
      fft_q   <= CNT_ONE;
      num_q   <= SYM_ONE;
      ap_done <= 1'b0;
    end else begin
      state   <= state_d;
      ap_done <= (state == ST_FLUSH) && out_hs;
      if (start_acc) begin
        cp_q    <= cfg_cp_len;
        fft_q   <= (cfg_fft_len == '0) ? CNT_ONE : cfg_fft_len;
        num_q   <= (cfg_num_sym == '0) ? SYM_ONE : cfg_num_sym;
        cnt     <= '0;
        sym_cnt <= '0;
      end else if (in_hs && state == ST_DROP) begin
        cnt <= cp_last ? '0 : cnt + CNT_ONE;
      end else if (load) begin
        if (fft_last) begin
          cnt <= '0;
          if (!sym_last) sym_cnt <= sym_cnt + SYM_ONE;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end
    end
  end

  assign ap_idle               = (state == ST_IDLE);
  assign inpstream_TDATA_blk_n = !(inpstream_TREADY && !inpstream_TVALID);
  assign oupstream_TDATA_blk_n = !(oupstream_TVALID && !oupstream_TREADY);

  cpr_out_reg #(.DATA_W(DATA_W)) u_out_reg (
    .clk       (ap_clk),
    .rst_n     (ap_rst_n),
    .load      (load),
    .load_data (inpstream_TDATA),
    .load_last (fft_last),
    .data      (oupstream_TDATA),
    .last      (oupstream_TLAST),
    .valid     (oupstream_TVALID),
    .ready     (oupstream_TREADY),
    .empty     (out_empty)
  );

`ifdef CPR_WATCHDOG_EN
  logic [WD_W-1:0] wd_cnt;

  // Counts blocked cycles between handshakes; the flag stays set until the next run starts.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      wd_cnt     <= '0;
      stall_flag <= 1'b0;
    end else if (start_acc) begin
      wd_cnt     <= '0;
      stall_flag <= 1'b0;
    end else begin
      if (in_hs || out_hs)
        wd_cnt <= '0;
      else if (state != ST_IDLE && (!inpstream_TDATA_blk_n || !oupstream_TDATA_blk_n) && wd_cnt != '1)
        wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == '1) stall_flag <= 1'b1;
    end
  end
`else
  // WD_W only sizes the watchdog; this compare is always false.
  assign stall_flag = (WD_W < 0);
`endif

endmodule

// File: tb/tb_cpr_stream_ctrl.sv
// Scoreboard bench for cpr_stream_ctrl: directed runs push expected beats, a monitor pops them.
module tb_cpr_stream_ctrl;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 12;
  localparam int SYM_W  = 16;
  localparam int WD_W   = 4;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n = 1'b0;
  logic              ap_start = 1'b0;
  logic              ap_done, ap_idle;
  logic [CNT_W-1:0]  cfg_cp_len = '0;
  logic [CNT_W-1:0]  cfg_fft_len = '0;
  logic [SYM_W-1:0]  cfg_num_sym = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid, out_last;
  logic              out_ready = 1'b1;
  logic              inp_blk_n, oup_blk_n, stall_flag;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  beat_t sb[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    done_cnt = 0;
  int    exp_done = 0;
  int    sink_mode = 0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;

  cpr_stream_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W), .SYM_W(SYM_W), .WD_W(WD_W)) dut (
    .ap_clk                (ap_clk),
    .ap_rst_n              (ap_rst_n),
    .ap_start              (ap_start),
    .ap_done               (ap_done),
    .ap_idle               (ap_idle),
    .cfg_cp_len            (cfg_cp_len),
    .cfg_fft_len           (cfg_fft_len),
    .cfg_num_sym           (cfg_num_sym),
    .inpstream_TDATA       (in_data),
    .inpstream_TVALID      (in_valid),
    .inpstream_TREADY      (in_ready),
    .oupstream_TDATA       (out_data),
    .oupstream_TVALID      (out_valid),
    .oupstream_TREADY      (out_ready),
    .oupstream_TLAST       (out_last),
    .inpstream_TDATA_blk_n (inp_blk_n),
    .oupstream_TDATA_blk_n (oup_blk_n),
    .stall_flag            (stall_flag)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sink: 0 = always ready, 1 = toggles every cycle, 2 = never ready.
  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      case (sink_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks hold-while-stalled.
  always @(negedge ap_clk) begin
    if (!ap_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (ap_done) done_cnt++;
      checkOutput("oup_blk_n", 32'(oup_blk_n), 32'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", out_data, prev_beat.data);
        checkOutput("hold_last", 32'(out_last), 32'(prev_beat.last));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_beat", out_data, 32'hDEAD_BEEF);
        end else begin
          beat_t e;
          e = sb.pop_front();
          checkOutput("out_data", out_data, e.data);
          checkOutput("out_last", 32'(out_last), 32'(e.last));
        end
      end
      prev_stall     = out_valid && !out_ready;
      prev_beat.data = out_data;
      prev_beat.last = out_last;
    end
  end

  task automatic checkResetState();
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst_ap_done", 32'(ap_done), 32'd0);
    checkOutput("rst_ap_idle", 32'(ap_idle), 32'd1);
    checkOutput("rst_stall_flag", 32'(stall_flag), 32'd0);
    checkOutput("rst_inp_blk_n", 32'(inp_blk_n), 32'd1);
    checkOutput("rst_oup_blk_n", 32'(oup_blk_n), 32'd1);
  endtask

  // Pushes the expected passed samples (data = input beat index) and pulses ap_start.
  task automatic startRun(input int cp, input int fft, input int num, output int total);
    int fe, ne;
    fe = (fft == 0) ? 1 : fft;
    ne = (num == 0) ? 1 : num;
    total = ne * (cp + fe);
    for (int s = 0; s < ne; s++)
      for (int i = 0; i < fe; i++) begin
        beat_t b;
        b.data = DATA_W'(s * (cp + fe) + cp + i);
        b.last = (i == fe - 1);
        sb.push_back(b);
      end
    cfg_cp_len  = CNT_W'(cp);
    cfg_fft_len = CNT_W'(fft);
    cfg_num_sym = SYM_W'(num);
    ap_start    = 1'b1;
    @(posedge ap_clk);
    #1;
    ap_start    = 1'b0;
    cfg_cp_len  = 12'd5;
    cfg_fft_len = 12'd3;
    cfg_num_sym = 16'd7;
  endtask

  task automatic sendBeat(input int d);
    int c;
    in_valid = 1'b1;
    in_data  = DATA_W'(d);
    c = 0;
    @(negedge ap_clk);
    while (!in_ready && c < 200) begin
      @(negedge ap_clk);
      c++;
    end
    if (c >= 200) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge ap_clk);
    #1;
  endtask

  task automatic waitDone();
    int c;
    exp_done++;
    c = 0;
    while (done_cnt < exp_done && c < 100) begin
      @(negedge ap_clk);
      c++;
    end
    repeat (2) @(negedge ap_clk);
    checkOutput("done_count", 32'(done_cnt), 32'(exp_done));
    checkOutput("idle_after_done", 32'(ap_idle), 32'd1);
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    @(posedge ap_clk);
    #1;
  endtask

  task automatic applyStimulus(input int cp, input int fft, input int num, input int gap_at);
    int total;
    startRun(cp, fft, num, total);
    for (int i = 0; i < total; i++) begin
      if (i == gap_at) begin
        in_valid = 1'b0;
        repeat (5) begin
          @(negedge ap_clk);
          checkOutput("inp_blk_n_gap", 32'(inp_blk_n), 32'd0);
        end
        @(posedge ap_clk);
        #1;
      end
      sendBeat(i);
    end
    in_valid = 1'b0;
    waitDone();
  endtask

  initial begin
    int total;
    repeat (2) @(posedge ap_clk);
    #1;
    checkResetState();
    ap_rst_n = 1'b1;

    $display("[TB] run cp=4 fft=8 sym=2, sink ready");
    applyStimulus(4, 8, 2, -1);
    $display("[TB] run cp=0 fft=4 sym=3");
    applyStimulus(0, 4, 3, -1);
    $display("[TB] run cp=4 fft=8 sym=2, sink toggling");
    sink_mode = 1;
    applyStimulus(4, 8, 2, -1);
    sink_mode = 0;
    $display("[TB] source gap mid-PASS");
    applyStimulus(4, 8, 1, 6);
    $display("[TB] zero-length clamp");
    applyStimulus(2, 0, 0, -1);

    $display("[TB] reset after three PASS beats");
    startRun(4, 8, 2, total);
    for (int i = 0; i < 7; i++) sendBeat(i);
    ap_rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge ap_clk);
    #1;
    checkResetState();
    sb.delete();
    ap_rst_n = 1'b1;
    applyStimulus(4, 8, 2, -1);

    $display("[TB] maximum fft length");
    applyStimulus(1, 4095, 1, -1);

`ifdef CPR_WATCHDOG_EN
    $display("[TB] watchdog");
    sink_mode = 2;
    startRun(0, 2, 1, total);
    sendBeat(0);
    in_valid = 1'b0;
    repeat (10) @(posedge ap_clk);
    @(negedge ap_clk);
    checkOutput("stall_early", 32'(stall_flag), 32'd0);
    repeat (10) @(posedge ap_clk);
    @(negedge ap_clk);
    checkOutput("stall_set", 32'(stall_flag), 32'd1);
    @(posedge ap_clk);
    #1;
    sink_mode = 0;
    sendBeat(1);
    in_valid = 1'b0;
    waitDone();
    checkOutput("stall_sticky", 32'(stall_flag), 32'd1);
    startRun(0, 1, 1, total);
    checkOutput("stall_cleared", 32'(stall_flag), 32'd0);
    sendBeat(0);
    in_valid = 1'b0;
    waitDone();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
